// File: rtl/core_bus_arbiter_pkg.sv
// Shared definitions for the core bus arbiter slice.
// FSM encodings and default sizing.
package core_bus_arbiter_pkg;

  localparam int MAX_CORES = 4;
  localparam int WIDTH     = 32;

  typedef enum logic {
    ARB_STATE_IDLE = 1'b0,
    ARB_STATE_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/core_bus_arbiter_rr_priority_select.sv
// Round-robin winner pick: first set request at or above the
// one-hot pointer, wrapping. Ports: req_i, ptr_i -> win_o (one-hot).
module rr_priority_select
  import core_bus_arbiter_pkg::*;
#(
  parameter int CORES = MAX_CORES
) (
  input  logic [CORES-1:0] req_i,
  input  logic [CORES-1:0] ptr_i,
  output logic [CORES-1:0] win_o
);

  logic [2*CORES-1:0] req2;
  logic [2*CORES-1:0] mask2;
  logic [2*CORES-1:0] masked;
  logic [2*CORES-1:0] pick;

  // Lower copy keeps only bits at/above the pointer; the upper
  // copy is unmasked so lower-index requests win after a wrap.
  assign req2   = {req_i, req_i};
  assign mask2  = {{CORES{1'b1}}, ~(ptr_i - CORES'(1))};
  assign masked = req2 & mask2;
  assign pick   = masked & (~masked + (2*CORES)'(1));
  assign win_o  = pick[CORES-1:0] | pick[2*CORES-1:CORES];

endmodule

// File: rtl/core_bus_arbiter.sv
// Round-robin arbiter sharing one bus among CORES cores with watchdog.
// Ports: Clock, Reset, iRequest, iDone, iAddress -> oGrant, oBusValid,
// oBusAddress, oBusy, oTimeout.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int CORES      = MAX_CORES,
  parameter int ADDR_WIDTH = WIDTH,
  parameter int TIMEOUT    = 255
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic [CORES-1:0]            iRequest,
  input  logic [CORES-1:0]            iDone,
  input  logic [CORES*ADDR_WIDTH-1:0] iAddress,
  output logic [CORES-1:0]            oGrant,
  output logic                        oBusValid,
  output logic [ADDR_WIDTH-1:0]       oBusAddress,
  output logic                        oBusy,
  output logic                        oTimeout
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [CORES-1:0] grant_q, grant_d;
  logic [CORES-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tout_q, tout_d;
  logic [CORES-1:0] win;
  logic [CORES-1:0] ptr_next;

  rr_priority_select #(
    .CORES (CORES)
  ) u_sel (
    .req_i (iRequest),
    .ptr_i (ptr_q),
    .win_o (win)
  );

  assign ptr_next = {grant_q[CORES-2:0], grant_q[CORES-1]};

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tout_d  = 1'b0;
    unique case (state_q)
      ARB_STATE_IDLE: begin
        if (|iRequest) begin
          grant_d = win;
          cnt_d   = '0;
          state_d = ARB_STATE_BUSY;
        end
      end
      ARB_STATE_BUSY: begin
        // Done beats abort beats timeout.
        if ((|(iDone & grant_q)) ||
            (~|(iRequest & grant_q)) ||
            (cnt_q == CNT_LAST)) begin
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ARB_STATE_IDLE;
          tout_d  = ~|(iDone & grant_q) &&
                    (|(iRequest & grant_q));
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ARB_STATE_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ARB_STATE_IDLE;
      grant_q <= '0;
      ptr_q   <= CORES'(1);
      cnt_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    oBusAddress = '0;
    for (int i = 0; i < CORES; i++) begin
      oBusAddress |= iAddress[i*ADDR_WIDTH +: ADDR_WIDTH]
                   & {ADDR_WIDTH{grant_q[i]}};
    end
  end

  assign oGrant    = grant_q;
  assign oBusValid = |grant_q;
  assign oBusy     = (state_q == ARB_STATE_BUSY);
  assign oTimeout  = tout_q;

endmodule
